// File: rtl/ik_swift_pkg.sv
// Purpose: shared constants and types for the ik_swift mat_mult scheduler.
// Latency: none (types, constants and one helper function).
// Backpressure: none.
package ik_swift_pkg;

  localparam int DIM   = 6;
  localparam int W     = 36;
  localparam int MAT_W = DIM * DIM * W;

  typedef logic [DIM-1:0][DIM-1:0][W-1:0] mat_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sched_state_t;

  // Requester slots on the shared multiplier.
  localparam int REQ_JAC = 0;
  localparam int REQ_INV = 1;
  localparam int REQ_DLS = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: round-robin pick of the lowest requesting index at or after ptr, wrapping.
// Latency: combinational (0 cycles).
// Backpressure: none; the caller decides when to act on gnt_next.
// Ports: req (request levels), ptr (search start) -> gnt_next (one-hot), gnt_idx (binary index).
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt_next,
  output logic [PTR_W-1:0] gnt_idx
);

  always_comb begin
    int   idx;
    logic found;
    gnt_next = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      // Walk ptr, ptr+1, ... with a single wrap back to 0.
      idx = int'(ptr) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!found && req[idx]) begin
        found         = 1'b1;
        gnt_next[idx] = 1'b1;
        gnt_idx       = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mat_mult_sched.sv
// Purpose: round-robin sequencer for the single shared mat_mult datapath (jacobian/inverse/dls).
// Latency: req sampled in IDLE at edge t -> gnt after t, done after t+1+LAT (LOAD + LAT RUN cycles).
// Backpressure: en=0 freezes every register; a pending done pulse stretches until en returns.
// Ports: req/mode/dataa/datab per requester in; gnt/done per requester out; busy; mm_rst,
//        mm_mode, mm_dataa, mm_datab drive the multiplier (operands are zero when nothing is granted).
module mat_mult_sched
  import ik_swift_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int LAT_MAT = 12,
  parameter int LAT_PAR = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         mode,
  input  logic [N_REQ*MAT_W-1:0]   dataa,
  input  logic [N_REQ*MAT_W-1:0]   datab,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic                     mm_rst,
  output logic                     mm_mode,
  output logic [MAT_W-1:0]         mm_dataa,
  output logic [MAT_W-1:0]         mm_datab
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(max_int(LAT_MAT, LAT_PAR));

  sched_state_t     state_q,   state_d;
  logic [N_REQ-1:0] gnt_q,     gnt_d;
  logic [N_REQ-1:0] done_q,    done_d;
  logic             mm_rst_q,  mm_rst_d;
  logic             mm_mode_q, mm_mode_d;
  mat_t             mm_dataa_q, mm_dataa_d;
  mat_t             mm_datab_q, mm_datab_d;
  logic [PTR_W-1:0] ptr_q,     ptr_d;
  logic [PTR_W-1:0] win_q,     win_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [PTR_W-1:0] arb_idx;
  mat_t             sel_a;
  mat_t             sel_b;
  logic             abort;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req      (req),
    .ptr      (ptr_q),
    .gnt_next (arb_gnt),
    .gnt_idx  (arb_idx)
  );

  // One-hot AND-OR mux of the candidate winner's operands.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_a = sel_a | dataa[i*MAT_W +: MAT_W];
        sel_b = sel_b | datab[i*MAT_W +: MAT_W];
      end
    end
  end

  // Winner withdrew before its result was ready: drop the op without a done.
  assign abort = ((state_q == LOAD) || (state_q == RUN)) && !req[win_q];

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    done_d     = done_q;
    mm_rst_d   = mm_rst_q;
    mm_mode_d  = mm_mode_q;
    mm_dataa_d = mm_dataa_q;
    mm_datab_d = mm_datab_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    cnt_d      = cnt_q;

    if (en) begin
      done_d   = '0;
      mm_rst_d = 1'b0;
      if (abort) begin
        state_d    = IDLE;
        gnt_d      = '0;
        mm_dataa_d = '0;
        mm_datab_d = '0;
        cnt_d      = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (|req) begin
              state_d    = LOAD;
              gnt_d      = arb_gnt;
              win_d      = arb_idx;
              mm_mode_d  = mode[arb_idx];
              mm_dataa_d = sel_a;
              mm_datab_d = sel_b;
              mm_rst_d   = 1'b1;
            end
          end
          LOAD: begin
            state_d = RUN;
            cnt_d   = mm_mode_q ? CNT_W'(LAT_MAT - 1) : CNT_W'(LAT_PAR - 1);
          end
          RUN: begin
            if (cnt_q == '0) begin
              state_d = DONE;
              done_d  = gnt_q;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          DONE: begin
            state_d    = IDLE;
            gnt_d      = '0;
            mm_dataa_d = '0;
            mm_datab_d = '0;
            ptr_d      = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      mm_rst_q   <= 1'b0;
      mm_mode_q  <= 1'b1;
      mm_dataa_q <= '0;
      mm_datab_q <= '0;
      ptr_q      <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      mm_rst_q   <= mm_rst_d;
      mm_mode_q  <= mm_mode_d;
      mm_dataa_q <= mm_dataa_d;
      mm_datab_q <= mm_datab_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);
  assign mm_rst   = mm_rst_q;
  assign mm_mode  = mm_mode_q;
  assign mm_dataa = mm_dataa_q;
  assign mm_datab = mm_datab_q;

endmodule

// File: tb/tb_mat_mult_sched.sv
// Purpose: self-checking bench for mat_mult_sched (directed scenarios plus random traffic).
// Latency: n/a.
// Backpressure: drives en randomly during the random phase.
module tb_mat_mult_sched;
  import ik_swift_pkg::*;

  localparam int NR   = 3;
  localparam int LMAT = 12;
  localparam int LPAR = 8;

  logic                clk;
  logic                rst_n;
  logic                en;
  logic [NR-1:0]       req;
  logic [NR-1:0]       mode;
  logic [NR*MAT_W-1:0] dataa;
  logic [NR*MAT_W-1:0] datab;
  logic [NR-1:0]       gnt;
  logic [NR-1:0]       done;
  logic                busy;
  logic                mm_rst;
  logic                mm_mode;
  logic [MAT_W-1:0]    mm_dataa;
  logic [MAT_W-1:0]    mm_datab;

  int checks   = 0;
  int failures = 0;

  mat_mult_sched #(.N_REQ(NR), .LAT_MAT(LMAT), .LAT_PAR(LPAR)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .mode(mode),
    .dataa(dataa), .datab(datab), .gnt(gnt), .done(done), .busy(busy),
    .mm_rst(mm_rst), .mm_mode(mm_mode), .mm_dataa(mm_dataa), .mm_datab(mm_datab)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic chk_mat(input string name, input logic [MAT_W-1:0] got, input logic [MAT_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got[127:0]=%h exp[127:0]=%h", name, got[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [MAT_W-1:0] rand_mat();
    logic [MAT_W-1:0] r;
    r = '0;
    for (int i = 0; i < (MAT_W + 31) / 32; i++) begin
      r = {r[MAT_W-33:0], 32'($urandom)};
    end
    return r;
  endfunction

  task automatic rand_data();
    dataa = {rand_mat(), rand_mat(), rand_mat()};
    datab = {rand_mat(), rand_mat(), rand_mat()};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference ----------------
  // An op is described by its age in cycles since the grant edge:
  // age 0 is the clear cycle, ages 1..LAT compute, age LAT+1 is the done cycle.
  bit               m_active;
  int               m_win;
  int               m_age;
  int               m_ptr;
  bit               m_mode;
  logic [MAT_W-1:0] m_a;
  logic [MAT_W-1:0] m_b;

  function automatic int m_lat();
    return m_mode ? LMAT : LPAR;
  endfunction

  task automatic m_reset();
    m_active = 0; m_win = 0; m_age = 0; m_ptr = 0; m_mode = 1;
    m_a = '0; m_b = '0;
  endtask

  task automatic m_step();
    int w;
    bit found;
    if (m_active) begin
      if (m_age <= m_lat() && !req[m_win]) begin
        m_active = 0; m_a = '0; m_b = '0;
      end else if (m_age == m_lat() + 1) begin
        m_active = 0; m_a = '0; m_b = '0;
        m_ptr = (m_win + 1) % NR;
      end else begin
        m_age++;
      end
    end else if (req != '0) begin
      found = 0; w = 0;
      for (int i = 0; i < NR; i++) begin
        if (!found && req[(m_ptr + i) % NR]) begin
          found = 1;
          w = (m_ptr + i) % NR;
        end
      end
      m_active = 1; m_win = w; m_age = 0;
      m_mode = mode[w];
      m_a = dataa[w*MAT_W +: MAT_W];
      m_b = datab[w*MAT_W +: MAT_W];
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else if (en) m_step();
    end
  end

  // Every cycle, away from the active edge, every output must match the reference.
  initial begin
    logic [NR-1:0] e_gnt;
    logic [NR-1:0] e_done;
    forever begin
      @(negedge clk);
      e_gnt  = m_active ? NR'(1 << m_win) : '0;
      e_done = (m_active && m_age == m_lat() + 1) ? NR'(1 << m_win) : '0;
      chk("mdl_gnt", 64'(gnt), 64'(e_gnt));
      chk("mdl_done", 64'(done), 64'(e_done));
      chk("mdl_busy", 64'(busy), 64'(m_active));
      chk("mdl_mm_rst", 64'(mm_rst), 64'(m_active && m_age == 0));
      chk("mdl_mm_mode", 64'(mm_mode), 64'(m_mode));
      chk_mat("mdl_dataa", mm_dataa, m_a);
      chk_mat("mdl_datab", mm_datab, m_b);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int oh2idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    logic [MAT_W-1:0] ea;
    logic [MAT_W-1:0] eb;
    logic [NR-1:0]    prev;
    logic [NR-1:0]    snap_small;
    logic [MAT_W-1:0] snap_a;
    int               ord[4];
    int               n_g;
    bit               gap_chk;
    bit               saw_done;

    rst_n = 1'b0; en = 1'b1; req = '0; mode = '0;
    dataa = '0; datab = '0;
    tick(); tick();
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_mm_mode", 64'(mm_mode), 64'h1);
    chk("rst_busy", 64'(busy), 64'h0);
    chk_mat("rst_dataa", mm_dataa, '0);
    rst_n = 1'b1;

    // Single matrix-mode request on slot 1.
    rand_data();
    req = 3'b010; mode = 3'b010;
    ea = dataa[1*MAT_W +: MAT_W];
    eb = datab[1*MAT_W +: MAT_W];
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 1) begin
        chk("t1_gnt", 64'(gnt), 64'h2);
        chk("t1_mm_rst_on", 64'(mm_rst), 64'h1);
        chk("t1_mm_mode", 64'(mm_mode), 64'h1);
        chk_mat("t1_dataa", mm_dataa, ea);
        rand_data();
      end
      if (k == 2) chk("t1_mm_rst_off", 64'(mm_rst), 64'h0);
      if (k == 13) chk("t1_done_early", 64'(done), 64'h0);
      if (k == 14) begin
        chk("t1_done", 64'(done), 64'h2);
        chk_mat("t1_dataa_held", mm_dataa, ea);
        chk_mat("t1_datab_held", mm_datab, eb);
        req = '0;
      end
      if (k == 15) begin
        chk("t1_done_clr", 64'(done), 64'h0);
        chk("t1_gnt_clr", 64'(gnt), 64'h0);
      end
    end

    // Parallel-mode request on slot 2 (ptr now 2).
    rand_data();
    req = 3'b100; mode = 3'b000;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 1) begin
        chk("t3_gnt", 64'(gnt), 64'h4);
        chk("t3_mm_mode", 64'(mm_mode), 64'h0);
      end
      if (k == 9) chk("t3_done_early", 64'(done), 64'h0);
      if (k == 10) begin
        chk("t3_done", 64'(done), 64'h4);
        req = '0;
      end
      if (k == 11) begin
        chk_mat("t3_dataa_zero", mm_dataa, '0);
        chk_mat("t3_datab_zero", mm_datab, '0);
      end
    end

    // All three request after reset; slot 0 keeps requesting after its done.
    do_reset();
    req = 3'b111; mode = 3'b111; rand_data();
    n_g = 0; prev = '0; gap_chk = 0;
    for (int c = 0; c < 80 && n_g < 4; c++) begin
      tick();
      if (gap_chk) begin
        chk("t2_gap_gnt", 64'(gnt), 64'h0);
        chk("t2_done_width", 64'(done), 64'h0);
        gap_chk = 0;
      end
      if (gnt != '0 && gnt != prev) begin
        ord[n_g] = oh2idx(gnt);
        n_g++;
      end
      prev = gnt;
      if (done != '0) begin
        gap_chk = 1;
        if (done[1]) req[1] = 1'b0;
        if (done[2]) req[2] = 1'b0;
      end
    end
    chk("t2_n_grants", 64'(n_g), 64'd4);
    if (n_g == 4) begin
      chk("t2_order0", 64'(ord[0]), 64'd0);
      chk("t2_order1", 64'(ord[1]), 64'd1);
      chk("t2_order2", 64'(ord[2]), 64'd2);
      chk("t2_order3", 64'(ord[3]), 64'd0);
    end
    req = '0;
    tick(); tick();

    // Slot 0 withdraws in its fifth compute cycle.
    do_reset();
    req = 3'b001; mode = 3'b001; rand_data();
    for (int k = 1; k <= 6; k++) tick();
    req = '0;
    tick();
    chk("t4_gnt_abort", 64'(gnt), 64'h0);
    chk("t4_busy_abort", 64'(busy), 64'h0);
    chk_mat("t4_dataa_abort", mm_dataa, '0);
    saw_done = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (done != '0) saw_done = 1;
    end
    chk("t4_no_done", 64'(saw_done), 64'h0);
    req = 3'b011;
    tick();
    chk("t4_same_ptr", 64'(gnt), 64'h1);
    req = '0;
    tick(); tick();

    // Reset in the third compute cycle.
    req = 3'b001; mode = 3'b001; rand_data();
    for (int k = 1; k <= 4; k++) tick();
    rst_n = 1'b0; req = '0;
    #1;
    chk("t5_gnt", 64'(gnt), 64'h0);
    chk("t5_busy", 64'(busy), 64'h0);
    chk("t5_mm_mode", 64'(mm_mode), 64'h1);
    chk_mat("t5_dataa", mm_dataa, '0);
    tick(); tick();
    rst_n = 1'b1;
    saw_done = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (done != '0) saw_done = 1;
    end
    chk("t5_no_done", 64'(saw_done), 64'h0);

    // Four frozen cycles in the middle of a matrix op.
    req = 3'b010; mode = 3'b010; rand_data();
    snap_small = '0; snap_a = '0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (k == 5) begin
        en = 1'b0;
        snap_small = gnt;
        snap_a = mm_dataa;
      end
      if (k >= 6 && k <= 9) begin
        chk("t6_frozen_gnt", 64'({gnt, busy, mm_rst, done}), 64'({snap_small, 1'b1, 1'b0, 3'b000}));
        chk_mat("t6_frozen_dataa", mm_dataa, snap_a);
        if (k == 9) en = 1'b1;
      end
      if (k == 14) chk("t6_done_not_at14", 64'(done), 64'h0);
      if (k == 17) chk("t6_done_early", 64'(done), 64'h0);
      if (k == 18) begin
        chk("t6_done", 64'(done), 64'h2);
        req = '0;
      end
    end

    // Random traffic checked against the reference every cycle.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      en = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < NR; i++) begin
        if (req[i]) begin
          if (done[i] && $urandom_range(0, 1) == 0) req[i] = 1'b0;
          else if (!done[i] && $urandom_range(0, 79) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          req[i] = 1'b1;
        end
      end
      mode = NR'($urandom);
      rand_data();
      tick();
    end

    req = '0; en = 1'b1;
    tick(); tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
